apb_fifo_scheduler: RTL and testbench
=====================================

# apb_fifo_scheduler

APB4 master that sequences the APB FIFO slave on behalf of three local requesters: a push stream, a pop stream and a depth-configuration port. It arbitrates between push and pop round-robin, gives configuration priority, and drains the FIFO before any depth change so reconfiguration is never silently dropped. It issues one APB transfer at a time, gated by the slave's `full`/`empty` flags, and sits between the local datapath and the FIFO slave's APB port.

## Interface
- `WIDTH`, 8: FIFO data width; must be ≤ 32.
- `FIFO_ADDR`, 32'h8000_0000: PADDR for data push/pop; bit 31 set selects the data path.
- `CFG_ADDR`, 32'h0000_0000: PADDR of the depth register.
---
- `PCLK`  in  1  clock; single clock domain.
- `PRESET`  in  1  reset, asynchronous, active-high.
- `push_valid`  in  1  push request.
- `push_data`  in  WIDTH  push payload.
- `push_ready`  out  1  push accepted this edge; combinational.
- `pop_req`  in  1  level pop request; held until `pop_valid`.
- `pop_valid`  out  1  one-cycle pulse, registered; `pop_data` valid.
- `pop_data`  out  WIDTH  popped word; registered.
- `cfg_valid`  in  1  depth-change request.
- `cfg_depth_sel`  in  6  one-hot depth: bit0=8 … bit5=256.
- `cfg_ready`  out  1  cfg accepted this edge; combinational.
- `cfg_err`  out  1  one-cycle pulse: cfg was not one-hot and was dropped.
- `depth_sel`  out  6  shadow of last successfully written depth; reset 6'b000001.
- `slv_err`  out  1  one-cycle pulse: a transfer completed with PSLVERR=1.
- `busy`  out  1  state ≠ IDLE.
- `PADDR` out 32, `PPROT` out 3, `PSEL` out 1, `PENABLE` out 1, `PWRITE` out 1, `PWDATA` out 32, `PSTRB` out 4: APB4 master outputs, all registered.
- `PREADY` in 1, `PRDATA` in 32, `PSLVERR` in 1: APB4 master inputs.
- `fifo_full`, `fifo_empty`  in  1 each: slave status flags.

## Operation
- FSM states: IDLE → SETUP → ACCESS → IDLE. SETUP always advances to ACCESS. ACCESS holds while PREADY=0 and returns to IDLE on PREADY=1.
- Grants are made only in IDLE, so every grant sees `fifo_full`/`fifo_empty` settled from the previous transfer.
- Eligibility:
  - cfg: `cfg_valid && fifo_empty`.
  - push: `push_valid && !fifo_full && !cfg_valid`. A pending cfg blocks pushes, which drains the FIFO.
  - pop: `pop_req && !fifo_empty`.
- Priority: cfg first, then round-robin between push and pop. `rr_last` records the last data grant and resets to "pop", so push wins the first tie.
- Invalid cfg: a non-one-hot `cfg_depth_sel` seen in IDLE with `cfg_valid=1` raises `cfg_ready`, produces a `cfg_err` pulse on the next cycle and issues no APB transfer. This check ignores `fifo_empty`.
- Transfer encodings:
  - push: PADDR=FIFO_ADDR, PWRITE=1, PWDATA=zero-extended `push_data`, PSTRB=4'hF.
  - pop: PADDR=FIFO_ADDR, PWRITE=0, PWDATA=0, PSTRB=4'h0.
  - cfg: PADDR=CFG_ADDR, PWRITE=1, PWDATA={26'b0, sel}, PSTRB=4'hF.
  - PPROT is always 3'b000.
- On completion:
  - pop: `pop_data`=PRDATA[WIDTH-1:0] and `pop_valid` pulses.
  - cfg: `depth_sel` updates only if PSLVERR=0.
  - any transfer with PSLVERR=1: `slv_err` pulses. A pop with PSLVERR=1 still pulses `pop_valid`.
- Cancellation: dropping `pop_req` before its grant cancels the pop. After the grant, the transfer completes regardless.

## Timing
- Reset (async, any state): FSM=IDLE; all APB outputs 0; `pop_valid`, `pop_data`, `cfg_err`, `slv_err` = 0; `depth_sel`=6'b000001; `rr_last`=pop. A reset during ACCESS abandons the transfer immediately.
- Grant at edge T (IDLE). T+1 is SETUP (PSEL=1, PENABLE=0). T+2 is ACCESS (PENABLE=1). With PREADY=1, IDLE is reached at T+3.
- Minimum of 3 cycles per transfer; each PREADY=0 cycle adds one.
- `pop_valid`/`pop_data` appear in the first IDLE cycle after completion, i.e. T+3 with no wait states.
- PADDR, PWRITE, PWDATA and PSTRB are stable from SETUP through the end of ACCESS and return to 0 in IDLE.

## Structure
- Package `apb_fifo_sched_pkg` holds:
  - the state enum `sched_state_e` (IDLE, SETUP, ACCESS);
  - the grant enum `grant_e` (NONE, PUSH, POP, CFG);
  - default address constants;
  - function `is_onehot6`.
- Sub-module `rr_arb2`: two-requester round-robin arbiter with a `last` register and an `advance` strobe. Everything else stays in the top module.

## Test plan
- Push 0xA5 after reset with slave PREADY=1: PSEL rises at T+1, PENABLE at T+2; PADDR=0x8000_0000, PWDATA=0x0000_00A5, PSTRB=0xF; `busy` clears at T+3.
- Push 3 words then pop 3: `pop_data` returns the same values in order, each with a one-cycle `pop_valid`; no APB transfer issues while `fifo_empty=1` and `pop_req=1`.
- `push_valid` and `pop_req` held together with FIFO non-empty, non-full: grants alternate push, pop, push, …, with push first after reset.
- `cfg_valid`=6'b000100 with 2 words queued: no push is granted, the pops drain the FIFO, then a write to 0x0 with PWDATA=0x4 is issued and `depth_sel`=6'b000100.
- `cfg_depth_sel`=6'b000110: `cfg_ready` is high, `cfg_err` pulses, no APB transfer occurs and `depth_sel` is unchanged.
- PREADY held low 2 cycles with PSLVERR=1 on completion: ACCESS lasts 3 cycles and `slv_err` pulses once. A separate run asserting PRESET mid-ACCESS: PSEL/PENABLE drop to 0 asynchronously and FSM=IDLE.

Source files
------------

// File: rtl/apb_fifo_sched_pkg.sv
// Shared types and helpers for the APB FIFO scheduler: FSM/grant encodings,
// default slave addresses and the depth-select validity check.
package apb_fifo_sched_pkg;

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} sched_state_e;
   typedef enum logic [1:0] {NONE, PUSH, POP, CFG} grant_e;

   localparam logic [31:0] FIFO_ADDR_DEF = 32'h8000_0000;
   localparam logic [31:0] CFG_ADDR_DEF  = 32'h0000_0000;

   function automatic logic is_onehot6(input logic [5:0] s);
      return (s != 6'd0) && ((s & (s - 6'd1)) == 6'd0);
   endfunction

endpackage

// File: rtl/apb_fifo_scheduler_if.sv
// APB4 bus between the scheduler (master) and the FIFO slave, plus the
// slave's full/empty status flags that gate every grant.
interface apb_fifo_scheduler_if;

   logic [31:0] PADDR;
   logic [2:0]  PPROT;
   logic        PSEL;
   logic        PENABLE;
   logic        PWRITE;
   logic [31:0] PWDATA;
   logic [3:0]  PSTRB;
   logic        PREADY;
   logic [31:0] PRDATA;
   logic        PSLVERR;
   logic        fifo_full;
   logic        fifo_empty;

   modport master (
      output PADDR, PPROT, PSEL, PENABLE, PWRITE, PWDATA, PSTRB,
      input  PREADY, PRDATA, PSLVERR, fifo_full, fifo_empty
   );

   modport slave (
      input  PADDR, PPROT, PSEL, PENABLE, PWRITE, PWDATA, PSTRB,
      output PREADY, PRDATA, PSLVERR, fifo_full, fifo_empty
   );

endinterface

// File: rtl/apb_fifo_scheduler_rr_arb2.sv
// Two-requester round-robin arbiter; last_q remembers which side won the
// previous advancing grant and resets to requester 1 so requester 0 wins first.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req_i,
   input  logic       advance_i,
   output logic [1:0] gnt_o
);

   logic last_q;

   always_comb begin
      gnt_o = req_i;
      if (req_i == 2'b11) gnt_o = last_q ? 2'b01 : 2'b10;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                              last_q <= 1'b1;
      else if (advance_i && gnt_o != 2'b00) last_q <= gnt_o[1];
   end

endmodule

// File: rtl/apb_fifo_scheduler.sv
// APB4 master sequencing a FIFO slave for push, pop and depth-config requesters;
// config has priority and blocks pushes so the FIFO drains before a depth change.
module apb_fifo_scheduler
   import apb_fifo_sched_pkg::*;
#(
   parameter int          WIDTH     = 8,
   parameter logic [31:0] FIFO_ADDR = FIFO_ADDR_DEF,
   parameter logic [31:0] CFG_ADDR  = CFG_ADDR_DEF
) (
   input  logic             PCLK,
   input  logic             PRESET,
   input  logic             push_valid,
   input  logic [WIDTH-1:0] push_data,
   output logic             push_ready,
   input  logic             pop_req,
   output logic             pop_valid,
   output logic [WIDTH-1:0] pop_data,
   input  logic             cfg_valid,
   input  logic [5:0]       cfg_depth_sel,
   output logic             cfg_ready,
   output logic             cfg_err,
   output logic [5:0]       depth_sel,
   output logic             slv_err,
   output logic             busy,
   apb_fifo_scheduler_if.master apb
);

   sched_state_e     state_q;
   grant_e           gnt_q, gnt_d;
   logic [31:0]      paddr_q, pwdata_q;
   logic [3:0]       pstrb_q;
   logic             psel_q, penable_q, pwrite_q;
   logic             pop_valid_q, cfg_err_q, slv_err_q;
   logic [WIDTH-1:0] pop_data_q;
   logic [5:0]       depth_sel_q;
   logic             idle, cfg_bad, cfg_ok, push_elig, pop_elig;
   logic [1:0]       arb_gnt;

   assign idle      = (state_q == IDLE);
   assign cfg_bad   = cfg_valid && !is_onehot6(cfg_depth_sel);
   assign cfg_ok    = cfg_valid && is_onehot6(cfg_depth_sel) && apb.fifo_empty;
   assign push_elig = push_valid && !apb.fifo_full && !cfg_valid;
   assign pop_elig  = pop_req && !apb.fifo_empty;

   rr_arb2 u_arb (
      .clk       (PCLK),
      .rst       (PRESET),
      .req_i     ({pop_elig, push_elig}),
      .advance_i (gnt_d == PUSH || gnt_d == POP),
      .gnt_o     (arb_gnt)
   );

   // A malformed config consumes the IDLE cycle so it is reported, not queued.
   always_comb begin
      gnt_d = NONE;
      if (idle && !cfg_bad) begin
         if (cfg_ok)          gnt_d = CFG;
         else if (arb_gnt[0]) gnt_d = PUSH;
         else if (arb_gnt[1]) gnt_d = POP;
      end
   end

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         state_q     <= IDLE;
         gnt_q       <= NONE;
         paddr_q     <= '0;
         pwdata_q    <= '0;
         pstrb_q     <= '0;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         pwrite_q    <= 1'b0;
         pop_valid_q <= 1'b0;
         pop_data_q  <= '0;
         cfg_err_q   <= 1'b0;
         slv_err_q   <= 1'b0;
         depth_sel_q <= 6'b000001;
      end else begin
         pop_valid_q <= 1'b0;
         cfg_err_q   <= 1'b0;
         slv_err_q   <= 1'b0;
         case (state_q)
            IDLE: begin
               cfg_err_q <= cfg_bad;
               if (gnt_d != NONE) begin
                  state_q <= SETUP;
                  gnt_q   <= gnt_d;
                  psel_q  <= 1'b1;
                  case (gnt_d)
                     PUSH: begin
                        paddr_q  <= FIFO_ADDR;
                        pwrite_q <= 1'b1;
                        pwdata_q <= 32'(push_data);
                        pstrb_q  <= 4'hF;
                     end
                     POP: begin
                        paddr_q  <= FIFO_ADDR;
                        pwrite_q <= 1'b0;
                        pwdata_q <= '0;
                        pstrb_q  <= 4'h0;
                     end
                     default: begin
                        paddr_q  <= CFG_ADDR;
                        pwrite_q <= 1'b1;
                        pwdata_q <= {26'b0, cfg_depth_sel};
                        pstrb_q  <= 4'hF;
                     end
                  endcase
               end
            end
            SETUP: begin
               state_q   <= ACCESS;
               penable_q <= 1'b1;
            end
            ACCESS: begin
               if (apb.PREADY) begin
                  state_q   <= IDLE;
                  gnt_q     <= NONE;
                  psel_q    <= 1'b0;
                  penable_q <= 1'b0;
                  paddr_q   <= '0;
                  pwrite_q  <= 1'b0;
                  pwdata_q  <= '0;
                  pstrb_q   <= '0;
                  slv_err_q <= apb.PSLVERR;
                  if (gnt_q == POP) begin
                     pop_valid_q <= 1'b1;
                     pop_data_q  <= apb.PRDATA[WIDTH-1:0];
                  end
                  // The depth just written still sits in PWDATA.
                  if (gnt_q == CFG && !apb.PSLVERR) depth_sel_q <= pwdata_q[5:0];
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign push_ready  = (gnt_d == PUSH);
   assign cfg_ready   = idle && (cfg_bad || gnt_d == CFG);
   assign pop_valid   = pop_valid_q;
   assign pop_data    = pop_data_q;
   assign cfg_err     = cfg_err_q;
   assign slv_err     = slv_err_q;
   assign depth_sel   = depth_sel_q;
   assign busy        = !idle;

   assign apb.PADDR   = paddr_q;
   assign apb.PPROT   = 3'b000;
   assign apb.PSEL    = psel_q;
   assign apb.PENABLE = penable_q;
   assign apb.PWRITE  = pwrite_q;
   assign apb.PWDATA  = pwdata_q;
   assign apb.PSTRB   = pstrb_q;

endmodule

// File: tb/tb_apb_fifo_scheduler.sv
// Bench for apb_fifo_scheduler: a queue-based FIFO slave on the APB side and a
// scoreboard of pushed words that every popped word must match in order.
module tb_apb_fifo_scheduler;
   import apb_fifo_sched_pkg::*;

   localparam int          WIDTH = 8;
   localparam logic [31:0] FA    = 32'h8000_0000;
   localparam logic [31:0] CA    = 32'h0000_0000;

   logic             PCLK = 1'b0;
   logic             PRESET = 1'b1;
   logic             push_valid = 1'b0;
   logic [WIDTH-1:0] push_data = '0;
   logic             push_ready;
   logic             pop_req = 1'b0;
   logic             pop_valid;
   logic [WIDTH-1:0] pop_data;
   logic             cfg_valid = 1'b0;
   logic [5:0]       cfg_depth_sel = '0;
   logic             cfg_ready, cfg_err, slv_err, busy;
   logic [5:0]       depth_sel;

   apb_fifo_scheduler_if apb();

   apb_fifo_scheduler #(.WIDTH(WIDTH)) dut (
      .PCLK(PCLK), .PRESET(PRESET),
      .push_valid(push_valid), .push_data(push_data), .push_ready(push_ready),
      .pop_req(pop_req), .pop_valid(pop_valid), .pop_data(pop_data),
      .cfg_valid(cfg_valid), .cfg_depth_sel(cfg_depth_sel), .cfg_ready(cfg_ready),
      .cfg_err(cfg_err), .depth_sel(depth_sel), .slv_err(slv_err), .busy(busy),
      .apb(apb)
   );

   always #5 PCLK = ~PCLK;

   typedef struct {
      logic [31:0] addr;
      logic        wr;
      logic [31:0] wdata;
      logic [3:0]  strb;
   } xfer_t;

   xfer_t            log_q[$];
   logic [31:0]      fq[$];
   logic [WIDTH-1:0] exp_q[$];
   int               slv_depth = 8;
   int               waits = 0;
   int               acc_cnt = 0;
   logic             err_resp = 1'b0;
   int               errors = 0;
   int               checks = 0;

   assign apb.PREADY  = (acc_cnt >= waits);
   assign apb.PSLVERR = err_resp;

   // FIFO slave: stores/returns words, honours depth writes, flags via NBA.
   always @(posedge PCLK or posedge PRESET) begin
      if (PRESET) acc_cnt <= 0;
      else if (apb.PSEL && apb.PENABLE) begin
         if (apb.PREADY) begin
            acc_cnt <= 0;
            log_q.push_back('{apb.PADDR, apb.PWRITE, apb.PWDATA, apb.PSTRB});
            if (!apb.PSLVERR) begin
               if (apb.PADDR == FA && apb.PWRITE) fq.push_back(apb.PWDATA);
               else if (apb.PADDR == FA && fq.size() > 0) void'(fq.pop_front());
               else if (apb.PADDR == CA && apb.PWRITE)
                  for (int i = 0; i < 6; i++) if (apb.PWDATA[i]) slv_depth <= 8 << i;
            end
         end else acc_cnt <= acc_cnt + 1;
      end
      apb.fifo_empty <= (fq.size() == 0);
      apb.fifo_full  <= (fq.size() >= slv_depth);
      apb.PRDATA     <= (fq.size() > 0) ? fq[0] : 32'h0;
   end

   task automatic tick();
      @(negedge PCLK);
   endtask

   task automatic reset_all(input int n_preload);
      logic [WIDTH-1:0] v;
      PRESET = 1'b1; tick(); PRESET = 1'b0;
      fq.delete(); exp_q.delete();
      for (int i = 0; i < n_preload; i++) begin
         v = WIDTH'($urandom);
         fq.push_back(32'(v)); exp_q.push_back(v);
      end
      tick(); tick();
   endtask

   task automatic do_push(input logic [WIDTH-1:0] d);
      int n = 0;
      xfer_t x;
      push_valid = 1'b1; push_data = d; #1;
      while (!push_ready && n < 50) begin tick(); #1; n++; end
      checks++;
      if (!push_ready) begin errors++; $display("FAIL push_grant timeout data=%h", d); end
      tick(); push_valid = 1'b0;
      n = 0;
      while (busy && n < 50) begin tick(); n++; end
      checks++;
      if (busy || log_q.size() == 0) begin
         errors++; $display("FAIL push_done busy=%b log=%0d", busy, log_q.size());
      end else begin
         x = log_q[log_q.size()-1];
         if (x.addr !== FA || x.wr !== 1'b1 || x.wdata !== 32'(d) || x.strb !== 4'hF) begin
            errors++;
            $display("FAIL push_enc got addr=%h wr=%b wd=%h st=%h want %h 1 %h F",
                     x.addr, x.wr, x.wdata, x.strb, FA, 32'(d));
         end
      end
      if (!err_resp) exp_q.push_back(d);
   endtask

   task automatic do_pop(output logic [WIDTH-1:0] d);
      int n = 0;
      xfer_t x;
      pop_req = 1'b1; tick();
      while (!pop_valid && n < 100) begin tick(); n++; end
      d = pop_data; pop_req = 1'b0;
      checks++;
      if (!pop_valid || log_q.size() == 0) begin
         errors++; $display("FAIL pop_valid timeout");
      end else begin
         x = log_q[log_q.size()-1];
         if (x.addr !== FA || x.wr !== 1'b0 || x.wdata !== 32'h0 || x.strb !== 4'h0) begin
            errors++;
            $display("FAIL pop_enc got addr=%h wr=%b wd=%h st=%h want %h 0 0 0",
                     x.addr, x.wr, x.wdata, x.strb, FA);
         end
      end
   endtask

   task automatic check_pop(input string nm);
      logic [WIDTH-1:0] d, e;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      do_pop(d);
      checks++;
      if (d !== e) begin errors++; $display("FAIL %s got %h want %h", nm, d, e); end
   endtask

   task automatic test_reset();
      PRESET = 1'b1; tick(); tick();
      checks++;
      if ({apb.PSEL, apb.PENABLE, apb.PWRITE} !== 3'b000 || apb.PADDR !== 32'h0 ||
          apb.PWDATA !== 32'h0 || apb.PSTRB !== 4'h0) begin
         errors++; $display("FAIL reset_apb got sel=%b en=%b addr=%h want zeros",
                            apb.PSEL, apb.PENABLE, apb.PADDR);
      end
      checks++;
      if ({pop_valid, cfg_err, slv_err, busy} !== 4'b0 || pop_data !== '0) begin
         errors++; $display("FAIL reset_out got pv=%b ce=%b se=%b busy=%b pd=%h want 0",
                            pop_valid, cfg_err, slv_err, busy, pop_data);
      end
      checks++;
      if (depth_sel !== 6'b000001) begin
         errors++; $display("FAIL reset_depth got %b want 000001", depth_sel);
      end
      PRESET = 1'b0; tick(); tick();
   endtask

   task automatic test_push_timing();
      push_valid = 1'b1; push_data = 8'hA5; #1;
      checks++;
      if (push_ready !== 1'b1) begin errors++; $display("FAIL t0_push_ready got %b want 1", push_ready); end
      tick(); push_valid = 1'b0;
      checks++;
      if (apb.PSEL !== 1'b1 || apb.PENABLE !== 1'b0 || apb.PADDR !== FA || apb.PWDATA !== 32'hA5 ||
          apb.PSTRB !== 4'hF || apb.PWRITE !== 1'b1 || apb.PPROT !== 3'b000 || busy !== 1'b1) begin
         errors++; $display("FAIL t1_setup got sel=%b en=%b addr=%h wd=%h st=%h wr=%b",
                            apb.PSEL, apb.PENABLE, apb.PADDR, apb.PWDATA, apb.PSTRB, apb.PWRITE);
      end
      tick();
      checks++;
      if (apb.PSEL !== 1'b1 || apb.PENABLE !== 1'b1 || apb.PWDATA !== 32'hA5 || apb.PADDR !== FA) begin
         errors++; $display("FAIL t2_access got sel=%b en=%b wd=%h want 1 1 a5",
                            apb.PSEL, apb.PENABLE, apb.PWDATA);
      end
      tick();
      checks++;
      if (busy !== 1'b0 || apb.PSEL !== 1'b0 || apb.PENABLE !== 1'b0 || apb.PADDR !== 32'h0) begin
         errors++; $display("FAIL t3_idle got busy=%b sel=%b en=%b addr=%h want 0",
                            busy, apb.PSEL, apb.PENABLE, apb.PADDR);
      end
      exp_q.push_back(8'hA5);
   endtask

   task automatic test_fifo_order();
      int n0, pv = 0;
      for (int i = 0; i < 3; i++) do_push(WIDTH'($urandom));
      for (int i = 0; i < 4; i++) check_pop("order_pop");
      n0 = log_q.size();
      pop_req = 1'b1;
      repeat (10) begin tick(); if (pop_valid) pv++; end
      pop_req = 1'b0;
      checks++;
      if (log_q.size() != n0 || pv != 0) begin
         errors++; $display("FAIL empty_pop got xfers=%0d pv=%0d want 0 0", log_q.size() - n0, pv);
      end
   endtask

   task automatic test_alternate();
      int n0, n = 0;
      logic took = 1'b0;
      logic [WIDTH-1:0] e;
      reset_all(3);
      n0 = log_q.size();
      push_valid = 1'b1; push_data = WIDTH'($urandom); pop_req = 1'b1;
      while (n < 200) begin
         #1;
         if (pop_valid) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
            checks++;
            if (pop_data !== e) begin errors++; $display("FAIL alt_pop got %h want %h", pop_data, e); end
         end
         if (log_q.size() >= n0 + 8 && !busy) break;
         if (push_ready) begin exp_q.push_back(push_data); took = 1'b1; end
         tick(); n++;
         if (took) begin push_data = WIDTH'($urandom); took = 1'b0; end
      end
      push_valid = 1'b0; pop_req = 1'b0;
      checks++;
      if (log_q.size() < n0 + 8) begin
         errors++; $display("FAIL alt_timeout got %0d xfers want 8", log_q.size() - n0);
      end else begin
         for (int i = 0; i < 8; i++) begin
            checks++;
            if (log_q[n0+i].wr !== ((i % 2) == 0)) begin
               errors++; $display("FAIL alt_order idx=%0d got wr=%b want %b", i, log_q[n0+i].wr, (i % 2) == 0);
            end
         end
      end
      checks++;
      if (exp_q.size() != 3) begin errors++; $display("FAIL alt_level got %0d want 3", exp_q.size()); end
   endtask

   task automatic test_cfg_drain();
      int n0, n = 0, pushes = 0;
      logic [WIDTH-1:0] e;
      reset_all(2);
      n0 = log_q.size();
      cfg_valid = 1'b1; cfg_depth_sel = 6'b000100;
      push_valid = 1'b1; push_data = WIDTH'($urandom); pop_req = 1'b1;
      while (n < 200) begin
         #1;
         if (pop_valid) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
            checks++;
            if (pop_data !== e) begin errors++; $display("FAIL drain_pop got %h want %h", pop_data, e); end
         end
         if (push_ready) pushes++;
         if (cfg_ready) break;
         tick(); n++;
      end
      push_valid = 1'b0; pop_req = 1'b0;
      tick(); cfg_valid = 1'b0;
      n = 0;
      while (busy && n < 50) begin tick(); n++; end
      checks++;
      if (pushes != 0) begin errors++; $display("FAIL drain_push got %0d grants want 0", pushes); end
      checks++;
      if (log_q.size() != n0 + 3) begin
         errors++; $display("FAIL drain_count got %0d want 3", log_q.size() - n0);
      end else begin
         checks++;
         if (log_q[n0].wr !== 1'b0 || log_q[n0+1].wr !== 1'b0 || log_q[n0+2].addr !== CA ||
             log_q[n0+2].wr !== 1'b1 || log_q[n0+2].wdata !== 32'h4 || log_q[n0+2].strb !== 4'hF) begin
            errors++; $display("FAIL drain_seq got cfg addr=%h wr=%b wd=%h want 0 1 4",
                               log_q[n0+2].addr, log_q[n0+2].wr, log_q[n0+2].wdata);
         end
      end
      checks++;
      if (depth_sel !== 6'b000100) begin errors++; $display("FAIL drain_depth got %b want 000100", depth_sel); end
   endtask

   task automatic test_cfg_invalid();
      int n0 = log_q.size();
      cfg_valid = 1'b1; cfg_depth_sel = 6'b000110; #1;
      checks++;
      if (cfg_ready !== 1'b1) begin errors++; $display("FAIL bad_ready got %b want 1", cfg_ready); end
      tick(); cfg_valid = 1'b0;
      checks++;
      if (cfg_err !== 1'b1 || busy !== 1'b0 || apb.PSEL !== 1'b0) begin
         errors++; $display("FAIL bad_err got err=%b busy=%b sel=%b want 1 0 0", cfg_err, busy, apb.PSEL);
      end
      tick();
      checks++;
      if (cfg_err !== 1'b0 || log_q.size() != n0 || depth_sel !== 6'b000100) begin
         errors++; $display("FAIL bad_after got err=%b xfers=%0d depth=%b want 0 0 000100",
                            cfg_err, log_q.size() - n0, depth_sel);
      end
   endtask

   task automatic test_wait_err();
      int acc = 0, se = 0;
      waits = 2; err_resp = 1'b1;
      push_valid = 1'b1; push_data = WIDTH'($urandom); #1;
      tick(); push_valid = 1'b0;
      repeat (10) begin
         if (apb.PSEL && apb.PENABLE) acc++;
         if (slv_err) se++;
         tick();
      end
      checks++;
      if (acc != 3) begin errors++; $display("FAIL wait_access got %0d cycles want 3", acc); end
      checks++;
      if (se != 1) begin errors++; $display("FAIL slv_err_pulse got %0d want 1", se); end
      waits = 0; err_resp = 1'b0;
   endtask

   task automatic test_reset_mid();
      waits = 6;
      push_valid = 1'b1; push_data = WIDTH'($urandom); #1;
      tick(); push_valid = 1'b0;
      tick();
      checks++;
      if (apb.PENABLE !== 1'b1) begin errors++; $display("FAIL mid_pre got en=%b want 1", apb.PENABLE); end
      #2 PRESET = 1'b1;
      #1;
      checks++;
      if (apb.PSEL !== 1'b0 || apb.PENABLE !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL mid_reset got sel=%b en=%b busy=%b want 0 0 0", apb.PSEL, apb.PENABLE, busy);
      end
      waits = 0;
      tick(); PRESET = 1'b0; tick(); tick();
   endtask

   task automatic test_random();
      for (int i = 0; i < 40; i++) begin
         waits = $urandom_range(2, 0);
         if (exp_q.size() == 0 || (exp_q.size() < 8 && $urandom_range(1, 0) == 1))
            do_push(WIDTH'($urandom));
         else
            check_pop("rand_pop");
      end
      while (exp_q.size() > 0) check_pop("rand_drain");
      waits = 0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_push_timing();
      test_fifo_order();
      test_alternate();
      test_cfg_drain();
      test_cfg_invalid();
      test_wait_err();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
